rtc_snapshot: RTL and testbench

Downstream consumer of the I2C RTC block: watches its once-per-second `tick` and 56-bit BCD `datetime_o`, and turns each new reading into range-checked binary fields. It holds those fields stable for the CPU register file and display logic, and adds a millisecond sub-counter and a staleness flag. Binary outputs update atomically, only after a full field-by-field conversion has passed validation.

---
 rtl/rtc_snapshot.sv | 229 ++++++++++++++++++++++
 tb/tb_rtc_snapshot.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_snapshot.sv
`timescale 1ns/1ps
// Converts each new BCD RTC reading into validated binary fields, committed atomically,
// with a free-running millisecond sub-counter and a staleness flag.
//
// state    | meaning
// S_IDLE   | waiting for a rising edge of tick
// S_CONV   | converting one BCD field per cycle into staging (SS..YY)
// S_COMMIT | publishing staging to outputs, or rejecting the snapshot
module rtc_snapshot #(
  parameter int CLK_HZ = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [55:0] datetime_i,
  output logic [6:0]  year,
  output logic [3:0]  month,
  output logic [4:0]  day,
  output logic [2:0]  weekday,
  output logic [4:0]  hour,
  output logic [5:0]  minute,
  output logic [5:0]  second,
  output logic [9:0]  millis,
  output logic        valid,
  output logic        stale,
  output logic        update,
  output logic        bcd_err
);

  localparam int PRE = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE - 1);
  localparam logic [31:0] STALE_TH = 32'(64'(CLK_HZ) * 2);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t state_q, state_d;
  logic tick_q, tick_d;
  logic [55:0] shadow_q, shadow_d;
  logic [2:0] field_idx_q, field_idx_d;
  logic err_acc_q, err_acc_d;
  logic [5:0] stg_ss_q, stg_ss_d, stg_mi_q, stg_mi_d;
  logic [4:0] stg_hh_q, stg_hh_d, stg_dd_q, stg_dd_d;
  logic [2:0] stg_wd_q, stg_wd_d;
  logic [3:0] stg_mo_q, stg_mo_d;
  logic [6:0] stg_yy_q, stg_yy_d;
  logic [6:0] year_q, year_d;
  logic [3:0] month_q, month_d;
  logic [4:0] day_q, day_d, hour_q, hour_d;
  logic [2:0] weekday_q, weekday_d;
  logic [5:0] minute_q, minute_d, second_q, second_d;
  logic [9:0] millis_q, millis_d;
  logic valid_q, valid_d, update_q, update_d, bcd_err_q, bcd_err_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [31:0] stale_cnt_q, stale_cnt_d;

  logic [7:0] raw, conv, lim_lo, lim_hi;
  logic [3:0] hi, lo;
  logic conv_err;

  // Field select with the control bits (ST, 12/24, LPYR) masked off before conversion.
  always_comb begin
    raw    = '0;
    lim_lo = 8'd0;
    lim_hi = 8'd99;
    case (field_idx_q)
      3'd0: begin raw = shadow_q[7:0]   & 8'h7f; lim_hi = 8'd59; end
      3'd1: begin raw = shadow_q[15:8]  & 8'h7f; lim_hi = 8'd59; end
      3'd2: begin raw = shadow_q[23:16] & 8'h3f; lim_hi = 8'd23; end
      3'd3: begin raw = shadow_q[31:24] & 8'h07; lim_lo = 8'd1; lim_hi = 8'd7; end
      3'd4: begin raw = shadow_q[39:32] & 8'h3f; lim_lo = 8'd1; lim_hi = 8'd31; end
      3'd5: begin raw = shadow_q[47:40] & 8'h1f; lim_lo = 8'd1; lim_hi = 8'd12; end
      default: begin raw = shadow_q[55:48]; lim_hi = 8'd99; end
    endcase
    hi = raw[7:4];
    lo = raw[3:0];
    conv = {1'b0, hi, 3'b000} + {3'b000, hi, 1'b0} + {4'b0000, lo};
    conv_err = (hi > 4'd9) | (lo > 4'd9) | (conv < lim_lo) | (conv > lim_hi);
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick;
    shadow_d    = shadow_q;
    field_idx_d = field_idx_q;
    err_acc_d   = err_acc_q;
    stg_ss_d    = stg_ss_q;
    stg_mi_d    = stg_mi_q;
    stg_hh_d    = stg_hh_q;
    stg_wd_d    = stg_wd_q;
    stg_dd_d    = stg_dd_q;
    stg_mo_d    = stg_mo_q;
    stg_yy_d    = stg_yy_q;
    year_d      = year_q;
    month_d     = month_q;
    day_d       = day_q;
    weekday_d   = weekday_q;
    hour_d      = hour_q;
    minute_d    = minute_q;
    second_d    = second_q;
    millis_d    = millis_q;
    valid_d     = valid_q;
    update_d    = 1'b0;
    bcd_err_d   = 1'b0;
    pre_d       = pre_q + 1'b1;
    stale_cnt_d = stale_cnt_q;

    if (pre_q == PRE_MAX) begin
      pre_d = '0;
      if (millis_q != 10'd999) millis_d = millis_q + 10'd1;
    end
    if (stale_cnt_q != 32'hffff_ffff) stale_cnt_d = stale_cnt_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (tick && !tick_q) begin
          shadow_d    = datetime_i;
          field_idx_d = 3'd0;
          err_acc_d   = 1'b0;
          state_d     = S_CONV;
        end
      end
      S_CONV: begin
        err_acc_d = err_acc_q | conv_err;
        case (field_idx_q)
          3'd0: stg_ss_d = conv[5:0];
          3'd1: stg_mi_d = conv[5:0];
          3'd2: stg_hh_d = conv[4:0];
          3'd3: stg_wd_d = conv[2:0];
          3'd4: stg_dd_d = conv[4:0];
          3'd5: stg_mo_d = conv[3:0];
          default: stg_yy_d = conv[6:0];
        endcase
        if (field_idx_q == 3'd6) state_d = S_COMMIT;
        else field_idx_d = field_idx_q + 3'd1;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (!err_acc_q) begin
          second_d    = stg_ss_q;
          minute_d    = stg_mi_q;
          hour_d      = stg_hh_q;
          weekday_d   = stg_wd_q;
          day_d       = stg_dd_q;
          month_d     = stg_mo_q;
          year_d      = stg_yy_q;
          update_d    = 1'b1;
          valid_d     = 1'b1;
          millis_d    = '0;
          pre_d       = '0;
          stale_cnt_d = '0;
        end else begin
          bcd_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tick_q      <= 1'b0;
      shadow_q    <= '0;
      field_idx_q <= '0;
      err_acc_q   <= 1'b0;
      stg_ss_q    <= '0;
      stg_mi_q    <= '0;
      stg_hh_q    <= '0;
      stg_wd_q    <= '0;
      stg_dd_q    <= '0;
      stg_mo_q    <= '0;
      stg_yy_q    <= '0;
      year_q      <= '0;
      month_q     <= '0;
      day_q       <= '0;
      weekday_q   <= '0;
      hour_q      <= '0;
      minute_q    <= '0;
      second_q    <= '0;
      millis_q    <= '0;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
      bcd_err_q   <= 1'b0;
      pre_q       <= '0;
      stale_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      shadow_q    <= shadow_d;
      field_idx_q <= field_idx_d;
      err_acc_q   <= err_acc_d;
      stg_ss_q    <= stg_ss_d;
      stg_mi_q    <= stg_mi_d;
      stg_hh_q    <= stg_hh_d;
      stg_wd_q    <= stg_wd_d;
      stg_dd_q    <= stg_dd_d;
      stg_mo_q    <= stg_mo_d;
      stg_yy_q    <= stg_yy_d;
      year_q      <= year_d;
      month_q     <= month_d;
      day_q       <= day_d;
      weekday_q   <= weekday_d;
      hour_q      <= hour_d;
      minute_q    <= minute_d;
      second_q    <= second_d;
      millis_q    <= millis_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
      bcd_err_q   <= bcd_err_d;
      pre_q       <= pre_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  assign year    = year_q;
  assign month   = month_q;
  assign day     = day_q;
  assign weekday = weekday_q;
  assign hour    = hour_q;
  assign minute  = minute_q;
  assign second  = second_q;
  assign millis  = millis_q;
  assign valid   = valid_q;
  assign stale   = (stale_cnt_q >= STALE_TH);
  assign update  = update_q;
  assign bcd_err = bcd_err_q;

endmodule

// File: tb/tb_rtc_snapshot.sv
`timescale 1ns/1ps
// Bench for rtc_snapshot: directed and random readings checked against an
// arithmetic model of the BCD rules, ms prescaler and stale threshold.
module tb_rtc_snapshot;
  localparam int CLK_HZ = 10000;

  logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
  logic [55:0] datetime_i = '0;
  logic [6:0] year;
  logic [3:0] month;
  logic [4:0] day, hour;
  logic [2:0] weekday;
  logic [5:0] minute, second;
  logic [9:0] millis;
  logic valid, stale, update, bcd_err;

  rtc_snapshot #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .tick(tick), .datetime_i(datetime_i),
    .year(year), .month(month), .day(day), .weekday(weekday), .hour(hour),
    .minute(minute), .second(second), .millis(millis), .valid(valid),
    .stale(stale), .update(update), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int upd_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    if (update === 1'b1) upd_cnt++;
    if (bcd_err === 1'b1) err_cnt++;
  end

  int vectors = 0, miscompares = 0;
  int exp_f[7];
  int mdl_f[7];
  bit exp_valid = 1'b0;
  int commit_cyc = 0;
  int msk[7]    = '{'h7f, 'h7f, 'h3f, 'h07, 'h3f, 'h1f, 'hff};
  int lo_lim[7] = '{0, 0, 0, 1, 1, 1, 0};
  int hi_lim[7] = '{59, 59, 23, 7, 31, 12, 99};
  string fname[7] = '{"second", "minute", "hour", "weekday", "day", "month", "year"};

  // Reference: elapsed cycles since the last good commit (or reset) define millis and stale.
  function automatic int exp_millis();
    int n = (cyc - commit_cyc) / (CLK_HZ / 1000);
    return (n > 999) ? 999 : n;
  endfunction

  function automatic bit exp_stale();
    return (cyc - commit_cyc) >= 2 * CLK_HZ;
  endfunction

  function automatic int act_f(input int i);
    case (i)
      0: return int'(second);
      1: return int'(minute);
      2: return int'(hour);
      3: return int'(weekday);
      4: return int'(day);
      5: return int'(month);
      default: return int'(year);
    endcase
  endfunction

  task automatic model(input logic [55:0] dt, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      int b, h, l;
      b = int'((dt >> (8 * i)) & 56'hff) & msk[i];
      h = b / 16;
      l = b % 16;
      mdl_f[i] = h * 10 + l;
      if (h > 9 || l > 9 || mdl_f[i] < lo_lim[i] || mdl_f[i] > hi_lim[i]) ok = 1'b0;
    end
  endtask

  task automatic gen(output logic [55:0] dt, input bit corrupt);
    dt = '0;
    for (int i = 0; i < 7; i++) begin
      int v, b;
      v = int'($urandom_range(hi_lim[i], lo_lim[i]));
      b = (v / 10) * 16 + v % 10;
      b = b | (int'($urandom) & ~msk[i] & 255);
      dt[8*i +: 8] = 8'(b);
    end
    if (corrupt) begin
      int k;
      k = int'($urandom_range(6, 0));
      dt[8*k +: 8] = 8'($urandom);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Launch one reading (tick edge or reset release with tick high) and check the commit.
  task automatic run_conv(input logic [55:0] dt, input bit from_reset, input int hold);
    bit ok;
    int seen, early;
    model(dt, ok);
    if (!from_reset) begin tick = 1'b0; @(negedge clk); end
    datetime_i = dt;
    if (from_reset) begin commit_cyc = cyc; reset = 1'b0; end
    else tick = 1'b1;
    seen = 0;
    early = 0;
    repeat (8) begin
      @(negedge clk); seen++;
      if (seen == hold) tick = 1'b0;
      if (update !== 1'b0 || bcd_err !== 1'b0) early++;
    end
    @(negedge clk); seen++;
    if (seen == hold) tick = 1'b0;
    vectors++;
    if (early != 0) begin miscompares++; $display("FAIL early_pulse dt=%h got %0d pulses before commit, want 0", dt, early); end
    if (ok) begin
      vectors++;
      if (update !== 1'b1 || bcd_err !== 1'b0) begin
        miscompares++; $display("FAIL commit_pulse dt=%h got update=%b bcd_err=%b, want 1/0", dt, update, bcd_err);
      end
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (act_f(i) !== mdl_f[i]) begin
          miscompares++; $display("FAIL %s dt=%h got %0d want %0d", fname[i], dt, act_f(i), mdl_f[i]);
        end
      end
      commit_cyc = cyc;
      exp_f = mdl_f;
      exp_valid = 1'b1;
    end else begin
      vectors++;
      if (update !== 1'b0 || bcd_err !== 1'b1) begin
        miscompares++; $display("FAIL reject_pulse dt=%h got update=%b bcd_err=%b, want 0/1", dt, update, bcd_err);
      end
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (act_f(i) !== exp_f[i]) begin
          miscompares++; $display("FAIL held_%s dt=%h got %0d want %0d", fname[i], dt, act_f(i), exp_f[i]);
        end
      end
    end
    vectors++;
    if (valid !== exp_valid) begin miscompares++; $display("FAIL valid dt=%h got %b want %b", dt, valid, exp_valid); end
    vectors++;
    if (millis !== 10'(exp_millis())) begin miscompares++; $display("FAIL commit_millis dt=%h got %0d want %0d", dt, millis, exp_millis()); end
    vectors++;
    if (stale !== exp_stale()) begin miscompares++; $display("FAIL commit_stale dt=%h got %b want %b", dt, stale, exp_stale()); end
    @(negedge clk); seen++;
    if (seen == hold) tick = 1'b0;
    vectors++;
    if (update !== 1'b0 || bcd_err !== 1'b0) begin
      miscompares++; $display("FAIL pulse_width dt=%h got update=%b bcd_err=%b, want 0/0", dt, update, bcd_err);
    end
    while (seen < hold) begin
      @(negedge clk); seen++;
      if (seen == hold) tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick = 1'b0;
    wait_cyc(3);
    vectors++;
    if ({year, month, day, weekday, hour, minute, second, millis, valid, stale, update, bcd_err} !== '0) begin
      miscompares++; $display("FAIL reset_outputs got y=%0d mo=%0d d=%0d ms=%0d v=%b s=%b u=%b e=%b want all 0",
                              year, month, day, millis, valid, stale, update, bcd_err);
    end
    reset = 1'b0;
    commit_cyc = cyc;
    for (int i = 0; i < 7; i++) exp_f[i] = 0;
    exp_valid = 1'b0;
    wait_cyc(25);
    vectors++;
    if (millis !== 10'(exp_millis()) || valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset got millis=%0d valid=%b want %0d/0", millis, valid, exp_millis());
    end
  endtask

  task automatic test_good_reading();
    run_conv(56'h25_06_15_03_23_59_D8, 1'b0, 1);
    vectors++;
    if ({year, month, day, weekday, hour, minute, second} !== {7'd25, 4'd6, 5'd15, 3'd3, 5'd23, 6'd59, 6'd58}) begin
      miscompares++; $display("FAIL good_fields got %0d-%0d-%0d wd%0d %0d:%0d:%0d want 25-6-15 wd3 23:59:58",
                              year, month, day, weekday, hour, minute, second);
    end
  endtask

  task automatic test_millis_step();
    wait_cyc(9 - (cyc - commit_cyc));
    vectors++;
    if (millis !== 10'd0) begin miscompares++; $display("FAIL millis_9clk got %0d want 0", millis); end
    wait_cyc(1);
    vectors++;
    if (millis !== 10'd1) begin miscompares++; $display("FAIL millis_10clk got %0d want 1", millis); end
  endtask

  task automatic test_bad_and_masks();
    run_conv(56'h25_06_15_03_23_5A_30, 1'b0, 1);
    run_conv(56'h25_13_15_03_10_20_30, 1'b0, 1);
    run_conv(56'h25_32_15_03_10_20_30, 1'b0, 1);
    vectors++;
    if (month !== 4'd12) begin miscompares++; $display("FAIL lpyr_month got %0d want 12", month); end
    run_conv(56'h25_06_15_00_10_20_30, 1'b0, 1);
  endtask

  task automatic test_random();
    logic [55:0] dt;
    for (int n = 0; n < 30; n++) begin
      gen(dt, ($urandom_range(1, 0) == 1));
      run_conv(dt, 1'b0, 1);
      wait_cyc(int'($urandom_range(40, 0)));
      vectors++;
      if (millis !== 10'(exp_millis())) begin
        miscompares++; $display("FAIL rand_millis iter=%0d got %0d want %0d", n, millis, exp_millis());
      end
    end
  endtask

  task automatic test_tick_hold();
    int c;
    c = upd_cnt;
    run_conv(56'h24_02_29_04_12_00_00, 1'b0, 50);
    wait_cyc(20);
    vectors++;
    if (upd_cnt - c != 1) begin miscompares++; $display("FAIL tick_hold got %0d updates want 1", upd_cnt - c); end
  endtask

  task automatic test_back_to_back();
    int c;
    bit ok;
    logic [55:0] dt;
    dt = 56'h30_11_30_07_08_45_12;
    model(dt, ok);
    c = upd_cnt;
    tick = 1'b0;
    @(negedge clk);
    datetime_i = dt;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_cyc(2);
    datetime_i = 56'h99_01_01_01_00_00_00;
    tick = 1'b1;
    wait_cyc(3);
    tick = 1'b0;
    wait_cyc(3);
    commit_cyc = cyc;
    exp_f = mdl_f;
    exp_valid = 1'b1;
    vectors++;
    if (update !== 1'b1) begin miscompares++; $display("FAIL b2b_commit got update=%b want 1", update); end
    vectors++;
    if (year !== 7'(mdl_f[6]) || second !== 6'(mdl_f[0])) begin
      miscompares++; $display("FAIL b2b_fields got y=%0d s=%0d want %0d/%0d", year, second, mdl_f[6], mdl_f[0]);
    end
    wait_cyc(30);
    vectors++;
    if (upd_cnt - c != 1) begin miscompares++; $display("FAIL b2b_count got %0d updates want 1", upd_cnt - c); end
  endtask

  task automatic test_saturate_and_stale();
    wait_cyc(10050 - (cyc - commit_cyc));
    vectors++;
    if (millis !== 10'd999) begin miscompares++; $display("FAIL millis_sat got %0d want 999", millis); end
    wait_cyc(15000 - (cyc - commit_cyc));
    vectors++;
    if (millis !== 10'd999 || stale !== 1'b0) begin
      miscompares++; $display("FAIL millis_hold got ms=%0d stale=%b want 999/0", millis, stale);
    end
    wait_cyc(19999 - (cyc - commit_cyc));
    vectors++;
    if (stale !== 1'b0) begin miscompares++; $display("FAIL stale_early got %b want 0", stale); end
    wait_cyc(1);
    vectors++;
    if (stale !== 1'b1) begin miscompares++; $display("FAIL stale_set got %b want 1", stale); end
    run_conv(56'h25_12_31_02_23_59_59, 1'b0, 1);
  endtask

  task automatic test_reset_mid_conv();
    int c, e;
    tick = 1'b0;
    @(negedge clk);
    datetime_i = 56'h26_01_01_04_00_00_01;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({year, month, day, weekday, hour, minute, second, millis, valid, stale, update, bcd_err} !== '0) begin
      miscompares++; $display("FAIL midreset_outputs got y=%0d ms=%0d v=%b u=%b want all 0", year, millis, valid, update);
    end
    @(negedge clk);
    reset = 1'b0;
    commit_cyc = cyc;
    for (int i = 0; i < 7; i++) exp_f[i] = 0;
    exp_valid = 1'b0;
    c = upd_cnt;
    e = err_cnt;
    wait_cyc(30);
    vectors++;
    if (upd_cnt != c || err_cnt != e || valid !== 1'b0) begin
      miscompares++; $display("FAIL midreset_quiet got upd=%0d err=%0d valid=%b want 0/0/0", upd_cnt - c, err_cnt - e, valid);
    end
    vectors++;
    if (millis !== 10'(exp_millis())) begin miscompares++; $display("FAIL midreset_millis got %0d want %0d", millis, exp_millis()); end
  endtask

  task automatic test_tick_at_release();
    reset = 1'b1;
    tick = 1'b1;
    wait_cyc(2);
    run_conv(56'h27_07_04_05_16_30_45, 1'b1, 1);
  endtask

  initial begin
    test_reset();
    test_good_reading();
    test_millis_step();
    test_bad_and_masks();
    test_random();
    test_tick_hold();
    test_back_to_back();
    test_saturate_and_stale();
    test_reset_mid_conv();
    test_tick_at_release();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
